// File: rtl/psram_wishbone_slave.sv
// psram_wishbone_slave
// Wishbone B4 pipelined slave that runs single asynchronous accesses on an
// external multiplexed address/data PSRAM bus (16-bit data, 24-bit word address).
// Each access has four phases: ADDR (NADV low), HOLD, DATA (NOE or NWE low,
// stretched by NWAIT) and RECOVER (NE high). ACK_O is issued in the first
// RECOVER clock.
// Optional feature macro: PSRAM_WAIT_TIMEOUT_EN. When it is defined, a data
// phase held off by NWAIT for WAIT_TIMEOUT_CYCLES clocks ends with ERR_O, and
// a read returns 16'hDEAD.
module psram_wishbone_slave #(
   parameter int ADDR_CYCLES         = 2,
   parameter int HOLD_CYCLES         = 1,
   parameter int DATA_CYCLES         = 4,
   parameter int RECOVERY_CYCLES     = 1,
   parameter int WAIT_TIMEOUT_CYCLES = 256
) (
   input  logic         CLK_I,
   input  logic         RST_I,
   input  logic         CYC_I,
   input  logic         STB_I,
   output logic         STALL_O,
   output logic         ACK_O,
   output logic         ERR_O,
   input  logic [24:1]  ADR_I,
   input  logic [15:0]  DAT_I,
   output logic [15:0]  DAT_O,
   input  logic         WE_I,
   input  logic [1:0]   SEL_I,
   output logic [23:16] psramA,
   inout  wire  [15:0]  psramAD,
   output logic         psramNE,
   output logic         psramNOE,
   output logic         psramNWE,
   output logic         psramNADV,
   input  logic         psramNWAIT,
   output logic         psramNUB,
   output logic         psramNLB
);

   // One counter width serves every phase and the wait timeout.
   localparam int CNT_MAX0 = (ADDR_CYCLES > HOLD_CYCLES) ? ADDR_CYCLES : HOLD_CYCLES;
   localparam int CNT_MAX1 = (DATA_CYCLES > RECOVERY_CYCLES) ? DATA_CYCLES : RECOVERY_CYCLES;
   localparam int CNT_MAX2 = (CNT_MAX0 > CNT_MAX1) ? CNT_MAX0 : CNT_MAX1;
   localparam int CNT_MAX  = (CNT_MAX2 > WAIT_TIMEOUT_CYCLES) ? CNT_MAX2 : WAIT_TIMEOUT_CYCLES;
   localparam int CW       = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_CYCLES - 1);
   localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_CYCLES - 1);
   localparam logic [CW-1:0] REC_LAST  = CW'(RECOVERY_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_HOLD,
      S_DATA,
      S_RECOVER
   } state_t;

   state_t          state_reg;
   logic [CW-1:0]   cnt_reg;
   logic [15:0]     wdat_reg;
   logic            we_reg;
   logic            drop_reg;
   logic            stall_reg;
   logic            ack_reg;
   logic [15:0]     dat_o_reg;
   logic [7:0]      a_reg;
   logic [15:0]     ad_out_reg;
   logic            ad_oe_reg;
   logic            ne_reg;
   logic            noe_reg;
   logic            nwe_reg;
   logic            nadv_reg;
   logic            nub_reg;
   logic            nlb_reg;
   logic            nwait_meta_reg;
   logic            nwait_s;
   logic            data_min;
   logic            data_tmo;
   logic            data_done;

`ifdef PSRAM_WAIT_TIMEOUT_EN
   localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT_CYCLES - 1);
   logic [CW-1:0]   wait_cnt_reg;
   logic            err_reg;
`endif

   // Two-flop synchronizer for the asynchronous NWAIT pin; idles at "not waiting".
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         nwait_meta_reg <= 1'b1;
         nwait_s        <= 1'b1;
      end else begin
         nwait_meta_reg <= psramNWAIT;
         nwait_s        <= nwait_meta_reg;
      end
   end

   // Data phase termination: minimum width reached and the device is ready (or timed out).
   always_comb begin
      data_min = (state_reg == S_DATA) && (cnt_reg == DATA_LAST);
      data_tmo = 1'b0;
`ifdef PSRAM_WAIT_TIMEOUT_EN
      data_tmo = data_min && !nwait_s && (wait_cnt_reg == WAIT_LAST);
`endif
      data_done = (data_min && nwait_s) || data_tmo;
   end

`ifdef PSRAM_WAIT_TIMEOUT_EN
   // Counts clocks the data phase is stretched beyond its minimum by NWAIT.
   always_ff @(posedge CLK_I) begin
      if (RST_I || state_reg != S_DATA) begin
         wait_cnt_reg <= '0;
      end else if (data_min && !nwait_s && wait_cnt_reg != WAIT_LAST) begin
         wait_cnt_reg <= wait_cnt_reg + CW'(1);
      end
   end
`endif

   // Access sequencer; every PSRAM pin and Wishbone response is a register.
   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_reg  <= S_IDLE;
         cnt_reg    <= '0;
         wdat_reg   <= '0;
         we_reg     <= 1'b0;
         drop_reg   <= 1'b0;
         stall_reg  <= 1'b0;
         ack_reg    <= 1'b0;
         dat_o_reg  <= '0;
         a_reg      <= '0;
         ad_out_reg <= '0;
         ad_oe_reg  <= 1'b0;
         ne_reg     <= 1'b1;
         noe_reg    <= 1'b1;
         nwe_reg    <= 1'b1;
         nadv_reg   <= 1'b1;
         nub_reg    <= 1'b1;
         nlb_reg    <= 1'b1;
`ifdef PSRAM_WAIT_TIMEOUT_EN
         err_reg    <= 1'b0;
`endif
      end else begin
         ack_reg <= 1'b0;
`ifdef PSRAM_WAIT_TIMEOUT_EN
         err_reg <= 1'b0;
`endif
         // A master that abandons its cycle still gets a complete PSRAM access,
         // only the termination is withheld.
         if (state_reg != S_IDLE && !CYC_I) begin
            drop_reg <= 1'b1;
         end
         unique case (state_reg)
            S_IDLE: begin
               if (CYC_I && STB_I) begin
                  state_reg  <= S_ADDR;
                  cnt_reg    <= '0;
                  wdat_reg   <= DAT_I;
                  we_reg     <= WE_I;
                  drop_reg   <= 1'b0;
                  stall_reg  <= 1'b1;
                  a_reg      <= ADR_I[24:17];
                  ad_out_reg <= ADR_I[16:1];
                  ad_oe_reg  <= 1'b1;
                  ne_reg     <= 1'b0;
                  nadv_reg   <= 1'b0;
                  nub_reg    <= ~SEL_I[1];
                  nlb_reg    <= ~SEL_I[0];
               end
            end
            S_ADDR: begin
               if (cnt_reg == ADDR_LAST) begin
                  state_reg <= S_HOLD;
                  cnt_reg   <= '0;
                  nadv_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_HOLD: begin
               if (cnt_reg == HOLD_LAST) begin
                  state_reg <= S_DATA;
                  cnt_reg   <= '0;
                  if (we_reg) begin
                     nwe_reg    <= 1'b0;
                     ad_out_reg <= wdat_reg;
                  end else begin
                     // Release AD on the same edge NOE falls so the two never overlap.
                     noe_reg   <= 1'b0;
                     ad_oe_reg <= 1'b0;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_DATA: begin
               if (cnt_reg != DATA_LAST) begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
               if (data_done) begin
                  state_reg <= S_RECOVER;
                  cnt_reg   <= '0;
                  ne_reg    <= 1'b1;
                  noe_reg   <= 1'b1;
                  nwe_reg   <= 1'b1;
                  nub_reg   <= 1'b1;
                  nlb_reg   <= 1'b1;
                  ad_oe_reg <= 1'b0;
`ifdef PSRAM_WAIT_TIMEOUT_EN
                  if (data_tmo) begin
                     err_reg <= !drop_reg && CYC_I;
                     if (!we_reg) begin
                        dat_o_reg <= 16'hDEAD;
                     end
                  end else begin
                     ack_reg <= !drop_reg && CYC_I;
                     if (!we_reg) begin
                        dat_o_reg <= psramAD;
                     end
                  end
`else
                  ack_reg <= !drop_reg && CYC_I;
                  if (!we_reg) begin
                     dat_o_reg <= psramAD;
                  end
`endif
               end
            end
            S_RECOVER: begin
               if (cnt_reg == REC_LAST) begin
                  state_reg <= S_IDLE;
                  cnt_reg   <= '0;
                  stall_reg <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            default: begin
               state_reg <= S_IDLE;
               cnt_reg   <= '0;
               stall_reg <= 1'b0;
            end
         endcase
      end
   end

   assign STALL_O   = stall_reg;
   assign ACK_O     = ack_reg;
   assign DAT_O     = dat_o_reg;
   assign psramA    = a_reg;
   assign psramAD   = ad_oe_reg ? ad_out_reg : 16'hzzzz;
   assign psramNE   = ne_reg;
   assign psramNOE  = noe_reg;
   assign psramNWE  = nwe_reg;
   assign psramNADV = nadv_reg;
   assign psramNUB  = nub_reg;
   assign psramNLB  = nlb_reg;
`ifdef PSRAM_WAIT_TIMEOUT_EN
   assign ERR_O     = err_reg;
`else
   assign ERR_O     = 1'b0;
`endif

endmodule

// File: doc/psram_wishbone_slave.md
Name: psram_wishbone_slave

Overview:
Wishbone B4 pipelined slave that drives an external asynchronous multiplexed-address/data PSRAM device bus, 16-bit data and 24-bit word address. It is the initiator counterpart of the FPGA-as-PSRAM adapter: it lets fabric masters reach a real PSRAM chip, or a second FPGA presenting a PSRAM interface. Accesses are single, asynchronous and non-burst. Each access has four phases: address/NADV, address hold, data, recovery. NWAIT is honoured in the data phase.

Parameters:
ADDR_CYCLES, 2, clocks NADV held low with address driven (min 1)
HOLD_CYCLES, 1, clocks address held on AD after NADV rises (min 1)
DATA_CYCLES, 4, minimum clocks NOE/NWE held low (min 3)
RECOVERY_CYCLES, 1, clocks NE held high between accesses (min 1)
WAIT_TIMEOUT_CYCLES, 256, data-phase NWAIT timeout; used only with the optional feature

Ports:
CLK_I  in  1  Wishbone clock; all logic on rising edge
RST_I  in  1  synchronous active-high reset
CYC_I  in  1  bus cycle in progress
STB_I  in  1  transfer strobe
STALL_O  out  1  slave cannot accept a request
ACK_O  out  1  normal termination, one-clock pulse
ERR_O  out  1  abnormal termination, one-clock pulse
ADR_I  in  24 [24:1]  word address
DAT_I  in  16  write data
DAT_O  out  16  read data
WE_I  in  1  write enable
SEL_I  in  2  byte lane selects
psramA  out  8 [23:16]  upper address
psramAD  inout  16  multiplexed address/data
psramNE  out  1  active-low chip select
psramNOE  out  1  active-low output enable
psramNWE  out  1  active-low write enable
psramNADV  out  1  active-low address valid
psramNWAIT  in  1  active-low wait, asynchronous
psramNUB  out  1  active-low upper byte enable
psramNLB  out  1  active-low lower byte enable

Behaviour:
- Reset, and any cycle RST_I=1 including mid-access: state IDLE. ACK_O, ERR_O = 0. DAT_O = 0. STALL_O = 0. NE, NOE, NWE, NADV, NUB, NLB = 1. psramA = 0. AD tri-stated. All counters cleared.
- psramNWAIT passes through a 2-flop synchronizer (nwait_s). The synchronizer resets to 1.
- STALL_O = 1 in every state except IDLE.
- IDLE: if CYC_I & STB_I, latch ADR_I, DAT_I, WE_I, SEL_I and go to ADDR. Call this accept cycle T.
- ADDR, ADDR_CYCLES clocks: NE=0, NADV=0, psramA=adr[24:17], AD driven with adr[16:1]. NUB/NLB = ~sel.
- HOLD, HOLD_CYCLES clocks: NADV=1, address still driven.
- DATA, read: NOE=0, AD tri-stated. Phase ends on the first clock where the counter has reached DATA_CYCLES and nwait_s=1.
  - On that edge, sample psramAD into DAT_O.
  - Next cycle: ACK_O=1.
- DATA, write: NWE=0, AD driven with latched write data. Phase ends under the same rule; next cycle ACK_O=1.
- RECOVER, RECOVERY_CYCLES clocks: NE, NOE, NWE, NADV, NUB, NLB = 1. AD tri-stated. Then return to IDLE.
- ACK/ERR is emitted in the first RECOVER clock.
- Zero-wait read/write latency: ACK_O at T+1+ADDR_CYCLES+HOLD_CYCLES+DATA_CYCLES, which is T+8 with defaults.
- Next accept is no earlier than ACK cycle + RECOVERY_CYCLES.
- DAT_O holds the last read value until the next read completes.
- CYC_I dropped mid-access: the PSRAM access runs to completion, because async timing cannot be aborted, but ACK_O/ERR_O are suppressed.
- SEL=00: a full access is still performed, with NUB=NLB=1.
- The AD output enable is never active while NOE=0, and switches only on phase boundaries.

Optional Feature:
PSRAM_WAIT_TIMEOUT_EN
- Defined: a counter runs while the data phase is extended by nwait_s=0.
  - When it reaches WAIT_TIMEOUT_CYCLES, the data phase is forced to end.
  - ERR_O pulses instead of ACK_O.
  - On a read, DAT_O = 16'hDEAD.
  - Recovery is unchanged.
- Undefined: no counter, no ERR path; ERR_O tied 0. The data phase extends indefinitely while nwait_s=0.

Test Plan:
- Reset then idle: all PSRAM strobes 1, AD tri-stated, STALL_O=0, DAT_O=0.
- Write ADR=0xABCDEF, DAT=0x1234, SEL=11, NWAIT=1 -> psramA=0x55, AD=0xE6F7 during NADV low for 2 clks; NWE low 4 clks with AD=0x1234; ACK_O at T+8; STALL_O high until T+9.
- Read, model drives AD=0xBEEF, NWAIT held low 10 clks into data phase -> ACK delayed by ≥8 clks; DAT_O=0xBEEF with ACK; NOE never low while AD driven by slave.
- Back-to-back reads with STB held -> second accept exactly one clock after the first ACK, with one NE-high clock between accesses.
- CYC_I dropped during ADDR, and separately RST_I asserted during DATA -> no ACK, and access completes. With RST_I: strobes high and AD released on the next clock.
- With PSRAM_WAIT_TIMEOUT_EN and WAIT_TIMEOUT_CYCLES=16, NWAIT stuck low -> ERR_O pulse, DAT_O=0xDEAD, no ACK_O.
